// File: rtl/game_sequencer.sv
// Game-flow controller for the whack-a-mole datapath: IDLE -> countdown -> play -> over.
// Owns the phase timer, the per-game score and the session high score, and drives the display mux.
module game_sequencer #(
  parameter int COUNTDOWN_SEC = 5,
  parameter int GAME_SEC      = 30,
  parameter int SCORE_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick_1hz,
  input  logic               start,
  input  logic               hit,
  output logic [1:0]         phase,
  output logic [5:0]         seconds_left,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               mole_en,
  output logic [SCORE_W-1:0] disp_value,
  output logic               game_done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    PLAY      = 2'd2,
    OVER      = 2'd3
  } phase_t;

  localparam logic [5:0] CD_LOAD   = 6'(COUNTDOWN_SEC);
  localparam logic [5:0] GAME_LOAD = 6'(GAME_SEC);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
    return (&v) ? v : v + SCORE_W'(1);
  endfunction

  phase_t             state, state_nxt;
  logic [5:0]         secs_nxt;
  logic [SCORE_W-1:0] score_nxt, high_nxt, score_hit;
  logic               done_nxt;
  logic               start_q, hit_q;
  logic               start_edge, hit_edge;

  assign start_edge = start & ~start_q;
  assign hit_edge   = hit & ~hit_q;
  assign score_hit  = hit_edge ? sat_inc(score) : score;

  // Edge registers power up high so a button held through reset never fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      seconds_left <= '0;
      score        <= '0;
      high_score   <= '0;
      game_done    <= 1'b0;
      start_q      <= 1'b1;
      hit_q        <= 1'b1;
    end else begin
      state        <= state_nxt;
      seconds_left <= secs_nxt;
      score        <= score_nxt;
      high_score   <= high_nxt;
      game_done    <= done_nxt;
      start_q      <= start;
      hit_q        <= hit;
    end
  end

  always_comb begin
    state_nxt = state;
    secs_nxt  = seconds_left;
    score_nxt = score;
    high_nxt  = high_score;
    done_nxt  = 1'b0;
    case (state)
      IDLE, OVER: begin
        // A start here reloads outright; a coincident tick is deliberately not applied.
        if (start_edge) begin
          state_nxt = COUNTDOWN;
          secs_nxt  = CD_LOAD;
          score_nxt = '0;
        end
      end
      COUNTDOWN: begin
        if (tick_1hz) begin
          if (seconds_left == 6'd1) begin
            state_nxt = PLAY;
            secs_nxt  = GAME_LOAD;
          end else begin
            secs_nxt = seconds_left - 6'd1;
          end
        end
      end
      PLAY: begin
        score_nxt = score_hit;
        if (tick_1hz) begin
          if (seconds_left == 6'd1) begin
            state_nxt = OVER;
            secs_nxt  = '0;
            done_nxt  = 1'b1;
            high_nxt  = (score_hit > high_score) ? score_hit : high_score;
          end else begin
            secs_nxt = seconds_left - 6'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign phase   = state;
  assign mole_en = (state == PLAY);

  always_comb begin
    case (state)
      IDLE:      disp_value = high_score;
      COUNTDOWN: disp_value = SCORE_W'(seconds_left);
      default:   disp_value = score;
    endcase
  end

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer: a default instance for the game flow and a
// 2-bit-score instance for saturation; each is held in reset while the other runs.
module tb_game_sequencer;

  logic clk = 1'b0;
  logic reset0, reset1, tick, start, hit;

  logic [1:0] phase0, phase1;
  logic [5:0] secs0, secs1;
  logic [7:0] score0, high0, disp0;
  logic [1:0] score1, high1, disp1;
  logic       mole0, mole1, done0, done1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  game_sequencer #(.COUNTDOWN_SEC(5), .GAME_SEC(30), .SCORE_W(8)) dut0 (
    .clk(clk), .reset(reset0), .tick_1hz(tick), .start(start), .hit(hit),
    .phase(phase0), .seconds_left(secs0), .score(score0), .high_score(high0),
    .mole_en(mole0), .disp_value(disp0), .game_done(done0)
  );

  game_sequencer #(.COUNTDOWN_SEC(2), .GAME_SEC(3), .SCORE_W(2)) dut1 (
    .clk(clk), .reset(reset1), .tick_1hz(tick), .start(start), .hit(hit),
    .phase(phase1), .seconds_left(secs1), .score(score1), .high_score(high1),
    .mole_en(mole1), .disp_value(disp1), .game_done(done1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step(1);
    tick = 1'b0;
  endtask

  task automatic hit_pulse(input int len);
    hit = 1'b1;
    step(len);
    hit = 1'b0;
    step(1);
  endtask

  task automatic start_pulse();
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
  endtask

  initial begin
    reset0 = 1'b1; reset1 = 1'b1;
    start = 1'b1; hit = 1'b0; tick = 1'b0;
    step(3);
    check("rst_phase", int'(phase0), 0);
    check("rst_secs",  int'(secs0),  0);
    check("rst_score", int'(score0), 0);
    check("rst_high",  int'(high0),  0);
    check("rst_done",  int'(done0),  0);
    check("rst_mole",  int'(mole0),  0);

    // start held through reset must not launch a game
    reset0 = 1'b0;
    step(3);
    check("held_start_phase", int'(phase0), 0);
    start = 1'b0;
    step(1);
    start = 1'b1;
    step(1);
    check("start_phase", int'(phase0), 1);
    check("start_secs",  int'(secs0),  5);
    check("start_disp",  int'(disp0),  5);
    start = 1'b0;

    hit_pulse(10);
    check("cd_hit_ignored", int'(score0), 0);
    check("cd_mole_off",    int'(mole0),  0);

    for (int i = 1; i <= 5; i++) begin
      tick_pulse();
      if (i < 5) begin
        check("cd_secs", int'(secs0), 5 - i);
        check("cd_disp", int'(disp0), 5 - i);
      end
    end
    check("play_phase", int'(phase0), 2);
    check("play_secs",  int'(secs0),  30);
    check("play_mole",  int'(mole0),  1);

    start_pulse();
    check("play_start_ignored", int'(phase0), 2);
    check("play_start_secs",    int'(secs0),  30);

    for (int i = 0; i < 3; i++) hit_pulse(10);
    check("three_hits", int'(score0), 3);
    check("play_disp",  int'(disp0),  3);

    repeat (29) tick_pulse();
    check("last_second",  int'(secs0), 1);
    check("no_done_yet",  int'(done0), 0);
    hit = 1'b1; tick = 1'b1;
    step(1);
    tick = 1'b0;
    check("final_hit_score", int'(score0), 4);
    check("over_phase",      int'(phase0), 3);
    check("done_pulse",      int'(done0),  1);
    check("over_high",       int'(high0),  4);
    check("over_secs",       int'(secs0),  0);
    check("over_disp",       int'(disp0),  4);
    check("over_mole",       int'(mole0),  0);
    step(1);
    check("done_one_clk", int'(done0), 0);
    hit = 1'b0;
    step(1);

    tick_pulse();
    check("over_tick_secs",  int'(secs0),  0);
    check("over_tick_phase", int'(phase0), 3);
    hit_pulse(2);
    check("over_score_frozen", int'(score0), 4);

    // start and tick together: load without decrement
    start = 1'b1; tick = 1'b1;
    step(1);
    start = 1'b0; tick = 1'b0;
    check("g2_phase", int'(phase0), 1);
    check("g2_secs",  int'(secs0),  5);
    check("g2_score", int'(score0), 0);
    check("g2_high",  int'(high0),  4);
    repeat (5) tick_pulse();
    check("g2_play", int'(phase0), 2);
    hit_pulse(3);
    repeat (30) tick_pulse();
    check("g2_over",  int'(phase0), 3);
    check("g2_done",  int'(done0),  1);
    check("g2_score_final", int'(score0), 1);
    check("g2_high_kept",   int'(high0),  4);
    check("g2_disp",        int'(disp0),  1);

    start_pulse();
    repeat (5) tick_pulse();
    hit_pulse(2);
    check("g3_score", int'(score0), 1);
    reset0 = 1'b1;
    #1;
    check("midrst_phase", int'(phase0), 0);
    check("midrst_score", int'(score0), 0);
    check("midrst_high",  int'(high0),  0);
    check("midrst_secs",  int'(secs0),  0);
    check("midrst_disp",  int'(disp0),  0);
    check("midrst_mole",  int'(mole0),  0);

    // narrow-score instance
    step(1);
    reset1 = 1'b0;
    step(1);
    start_pulse();
    check("n_phase", int'(phase1), 1);
    check("n_secs",  int'(secs1),  2);
    repeat (2) tick_pulse();
    check("n_play",      int'(phase1), 2);
    check("n_play_secs", int'(secs1),  3);
    for (int i = 0; i < 5; i++) hit_pulse(2);
    check("n_saturate", int'(score1), 3);
    check("n_disp",     int'(disp1),  3);
    reset1 = 1'b1;
    #1;
    check("n_rst_phase", int'(phase1), 0);
    check("n_rst_score", int'(score1), 0);
    check("n_rst_secs",  int'(secs1),  0);
    check("n_rst_high",  int'(high1),  0);
    check("n_rst_mole",  int'(mole1),  0);
    check("n_rst_done",  int'(done1),  0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
